// File: rtl/tt_vga_io_frontend_if.sv
// Pin-side bundle for tt_vga_io_frontend: buttons, config word, video in, PMOD byte out.
// master = the side driving pins and timing (top/bench); slave = the front end itself.
interface tt_vga_io_frontend_if #(
  parameter int N_BTN      = 3,
  parameter int CFG_W      = 8,
  parameter int COLOR_BITS = 1
);
  logic [N_BTN-1:0]      btn_raw;
  logic [N_BTN-1:0]      btn_level;
  logic [N_BTN-1:0]      btn_rise;
  logic                  cfg_override;
  logic [CFG_W-1:0]      cfg_ext;
  logic                  frame_start;
  logic [CFG_W-1:0]      cfg_active;
  logic                  cfg_changed;
  logic                  vid_hs;
  logic                  vid_vs;
  logic                  vid_blank;
  logic [COLOR_BITS-1:0] vid_r;
  logic [COLOR_BITS-1:0] vid_g;
  logic [COLOR_BITS-1:0] vid_b;
  logic                  tp_en;
  logic [7:0]            pmod_out;

  modport master (
    output btn_raw, cfg_override, cfg_ext, frame_start,
           vid_hs, vid_vs, vid_blank, vid_r, vid_g, vid_b, tp_en,
    input  btn_level, btn_rise, cfg_active, cfg_changed, pmod_out
  );

  modport slave (
    input  btn_raw, cfg_override, cfg_ext, frame_start,
           vid_hs, vid_vs, vid_blank, vid_r, vid_g, vid_b, tp_en,
    output btn_level, btn_rise, cfg_active, cfg_changed, pmod_out
  );
endinterface

// File: rtl/tt_vga_io_frontend.sv
// TinyTapeout I/O front end: button sync/debounce, frame-latched config, TinyVGA PMOD packing.
// Optional test-bar generator enabled by defining TT_IO_TESTPAT_EN.
module tt_vga_io_frontend #(
  parameter int              N_BTN       = 3,
  parameter int              DEBOUNCE_W  = 16,
  parameter int              CFG_W       = 8,
  parameter logic [CFG_W-1:0] CFG_DEFAULT = 8'h42,
  parameter int              COLOR_BITS  = 1,
  parameter int              BAR_SHIFT   = 6
) (
  input logic                clk,
  input logic                rst_n,
  tt_vga_io_frontend_if.slave io
);
  localparam logic [DEBOUNCE_W-1:0] CNT_MAX = {DEBOUNCE_W{1'b1}};

  logic [N_BTN-1:0] level_vec;
  logic [N_BTN-1:0] rise_vec;

  // Each button: 2-flop synchroniser, then a counter that must saturate
  // with the synced value disagreeing with level before level follows.
  for (genvar gi = 0; gi < N_BTN; gi++) begin : g_btn
    logic [1:0]            sync_q;
    logic                  level_q;
    logic                  rise_q;
    logic [DEBOUNCE_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sync_q  <= '0;
        level_q <= 1'b0;
        rise_q  <= 1'b0;
        cnt_q   <= '0;
      end else begin
        sync_q <= {sync_q[0], io.btn_raw[gi]};
        rise_q <= 1'b0;
        if (sync_q[1] == level_q) begin
          cnt_q <= '0;
        end else if (cnt_q == CNT_MAX) begin
          level_q <= sync_q[1];
          rise_q  <= sync_q[1];
          cnt_q   <= '0;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end
    end

    assign level_vec[gi] = level_q;
    assign rise_vec[gi]  = rise_q;
  end

  assign io.btn_level = level_vec;
  assign io.btn_rise  = rise_vec;

  logic [CFG_W-1:0] cfg_sel;
  logic [CFG_W-1:0] cfg_active_q;
  logic             cfg_changed_q;

  assign cfg_sel = io.cfg_override ? io.cfg_ext : CFG_DEFAULT;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_active_q  <= CFG_DEFAULT;
      cfg_changed_q <= 1'b0;
    end else begin
      cfg_changed_q <= 1'b0;
      if (io.frame_start) begin
        cfg_active_q  <= cfg_sel;
        cfg_changed_q <= (cfg_sel != cfg_active_q);
      end
    end
  end

  assign io.cfg_active  = cfg_active_q;
  assign io.cfg_changed = cfg_changed_q;

  logic [COLOR_BITS-1:0] col_r, col_g, col_b;

`ifdef TT_IO_TESTPAT_EN
  // Pixel counter only needs the bits that select the bar index.
  logic [BAR_SHIFT+2:0] px_q;
  logic [2:0]           bar_idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            px_q <= '0;
    else if (io.vid_blank) px_q <= '0;
    else                   px_q <= px_q + 1'b1;
  end

  assign bar_idx = px_q[BAR_SHIFT+2:BAR_SHIFT];
  assign col_r   = io.tp_en ? {COLOR_BITS{bar_idx[0]}} : io.vid_r;
  assign col_g   = io.tp_en ? {COLOR_BITS{bar_idx[1]}} : io.vid_g;
  assign col_b   = io.tp_en ? {COLOR_BITS{bar_idx[2]}} : io.vid_b;
`else
  logic unused_tp_en;
  assign unused_tp_en = io.tp_en;
  assign col_r = io.vid_r;
  assign col_g = io.vid_g;
  assign col_b = io.vid_b;
`endif

  logic r_msb, r_lsb, g_msb, g_lsb, b_msb, b_lsb;

  // PMOD has two bits per channel; a 1-bit colour drives both.
  if (COLOR_BITS == 1) begin : g_c1
    assign {r_msb, r_lsb} = {2{col_r[0]}};
    assign {g_msb, g_lsb} = {2{col_g[0]}};
    assign {b_msb, b_lsb} = {2{col_b[0]}};
  end else begin : g_c2
    assign {r_msb, r_lsb} = col_r[1:0];
    assign {g_msb, g_lsb} = col_g[1:0];
    assign {b_msb, b_lsb} = col_b[1:0];
  end

  logic       vis;
  logic [7:0] pmod_d;
  logic [7:0] pmod_q;

  assign vis    = ~io.vid_blank;
  assign pmod_d = {io.vid_hs, b_msb & vis, g_msb & vis, r_msb & vis,
                   io.vid_vs, b_lsb & vis, g_lsb & vis, r_lsb & vis};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pmod_q <= 8'h00;
    else        pmod_q <= pmod_d;
  end

  assign io.pmod_out = pmod_q;
endmodule

// File: tb/tb_tt_vga_io_frontend.sv
// Directed scoreboard bench for tt_vga_io_frontend (1-bit and 2-bit colour instances).
module tb_tt_vga_io_frontend;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  tt_vga_io_frontend_if #(.N_BTN(3), .CFG_W(8), .COLOR_BITS(1)) if1 ();
  tt_vga_io_frontend_if #(.N_BTN(3), .CFG_W(8), .COLOR_BITS(2)) if2 ();

  tt_vga_io_frontend #(.N_BTN(3), .DEBOUNCE_W(4), .CFG_W(8), .CFG_DEFAULT(8'h42),
                       .COLOR_BITS(1), .BAR_SHIFT(6))
    dut1 (.clk(clk), .rst_n(rst_n), .io(if1));

  tt_vga_io_frontend #(.N_BTN(3), .DEBOUNCE_W(4), .CFG_W(8), .CFG_DEFAULT(8'h42),
                       .COLOR_BITS(2), .BAR_SHIFT(6))
    dut2 (.clk(clk), .rst_n(rst_n), .io(if2));

  logic [31:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic push(input logic [31:0] v);
    exp_q.push_back(v);
  endtask

  task automatic check(input string tag, input logic [31:0] obs);
    logic [31:0] exp;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s: observed %0h, scoreboard empty", tag, obs);
      return;
    end
    exp = exp_q.pop_front();
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Independent model of the PMOD byte for 1-bit colour.
  function automatic logic [7:0] pmod1(input logic hs, vs, r, g, b, blank);
    logic rr, gg, bb;
    rr = r & ~blank; gg = g & ~blank; bb = b & ~blank;
    return {hs, bb, gg, rr, vs, bb, gg, rr};
  endfunction

  task automatic step();
    @(negedge clk);
  endtask

  int first_k;
  logic rise_at_first;
  int rise_cnt;
  logic lvl_seen, rise_seen;

  initial begin
    if1.btn_raw = '0; if1.cfg_override = 0; if1.cfg_ext = '0; if1.frame_start = 0;
    if1.vid_hs = 0; if1.vid_vs = 0; if1.vid_blank = 1; if1.vid_r = '0; if1.vid_g = '0;
    if1.vid_b = '0; if1.tp_en = 0;
    if2.btn_raw = '0; if2.cfg_override = 0; if2.cfg_ext = '0; if2.frame_start = 0;
    if2.vid_hs = 0; if2.vid_vs = 0; if2.vid_blank = 1; if2.vid_r = '0; if2.vid_g = '0;
    if2.vid_b = '0; if2.tp_en = 0;

    repeat (3) step();
    push(0);     check("rst_btn_level", if1.btn_level);
    push(0);     check("rst_btn_rise", if1.btn_rise);
    push(8'h42); check("rst_cfg_active", if1.cfg_active);
    push(0);     check("rst_cfg_changed", if1.cfg_changed);
    push(0);     check("rst_pmod", if1.pmod_out);
    rst_n = 1'b1;
    repeat (2) step();

    // Button 0 debounce latency and single-cycle rise.
    if1.btn_raw[0] = 1'b1;
    first_k = 0; rise_at_first = 0; rise_cnt = 0;
    for (int k = 1; k <= 30; k++) begin
      step();
      if (if1.btn_rise[0]) rise_cnt++;
      if (if1.btn_level[0] && first_k == 0) begin
        first_k = k;
        rise_at_first = if1.btn_rise[0];
      end
    end
    push(18); check("btn0_latency", first_k);
    push(1);  check("btn0_rise_with_level", rise_at_first);
    push(1);  check("btn0_rise_width", rise_cnt);

    // Button 1 glitches shorter than the debounce window.
    lvl_seen = 0; rise_seen = 0;
    if1.btn_raw[1] = 1'b1; step(); if1.btn_raw[1] = 1'b0;
    for (int k = 0; k < 60; k++) begin
      if (k == 5)  if1.btn_raw[1] = 1'b1;
      if (k == 15) if1.btn_raw[1] = 1'b0;
      step();
      lvl_seen  |= if1.btn_level[1];
      rise_seen |= if1.btn_rise[1];
    end
    push(0); check("btn1_glitch_level", lvl_seen);
    push(0); check("btn1_glitch_rise", rise_seen);

    // Config: override only takes effect at frame_start.
    if1.frame_start = 1; step(); if1.frame_start = 0;
    push(8'h42); check("cfg_default_frame", if1.cfg_active);
    push(0);     check("cfg_default_nochange", if1.cfg_changed);
    if1.cfg_override = 1; if1.cfg_ext = 8'h5A;
    repeat (4) step();
    push(8'h42); check("cfg_midframe_hold", if1.cfg_active);
    if1.frame_start = 1; step(); if1.frame_start = 0;
    push(8'h5A); check("cfg_after_fs", if1.cfg_active);
    push(1);     check("cfg_changed_pulse", if1.cfg_changed);
    step();
    push(0);     check("cfg_changed_drop", if1.cfg_changed);
    if1.frame_start = 1; step(); if1.frame_start = 0;
    push(0);     check("cfg_repeat_fs_changed", if1.cfg_changed);
    if1.cfg_ext = 8'h33; step(); step();
    push(8'h5A); check("cfg_between_pulses", if1.cfg_active);
    if1.cfg_ext = 8'h77; if1.frame_start = 1; step(); if1.frame_start = 0;
    if1.cfg_ext = 8'h11;
    push(8'h77); check("cfg_sample_in_fs_cycle", if1.cfg_active);
    if1.cfg_override = 0; if1.frame_start = 1; step(); if1.frame_start = 0;
    push(8'h42); check("cfg_back_to_default", if1.cfg_active);
    push(1);     check("cfg_back_changed", if1.cfg_changed);

    // Video packing, 1-bit and 2-bit colour.
    if1.vid_hs = 1; if1.vid_vs = 0; if1.vid_r = 1; if1.vid_g = 0; if1.vid_b = 1; if1.vid_blank = 0;
    if2.vid_hs = 0; if2.vid_vs = 0; if2.vid_r = 2'b10; if2.vid_g = 2'b01; if2.vid_b = 2'b11;
    if2.vid_blank = 0;
    step();
    push(8'b1101_0101); check("pmod1_active", if1.pmod_out);
    push(8'b0101_0110); check("pmod2_active", if2.pmod_out);
    if1.vid_blank = 1; if2.vid_blank = 1;
    step();
    push(8'b1000_0000); check("pmod1_blank", if1.pmod_out);
    push(8'h00);        check("pmod2_blank", if2.pmod_out);
    if1.vid_hs = 0; if1.vid_vs = 1; if1.vid_r = 0; if1.vid_g = 1; if1.vid_b = 0; if1.vid_blank = 0;
    step();
    push(pmod1(0, 1, 0, 1, 0, 0)); check("pmod1_vs_green", if1.pmod_out);

`ifdef TT_IO_TESTPAT_EN
    // Test bars: one line of blanking, then 640 active pixels.
    if1.vid_hs = 0; if1.vid_vs = 0; if1.vid_r = 0; if1.vid_g = 0; if1.vid_b = 0;
    if1.vid_blank = 1; if1.tp_en = 1;
    step();
    if1.vid_blank = 0;
    for (int p = 0; p < 640; p++) begin
      logic [2:0] idx;
      idx = 3'((p >> 6) & 7);
      step();
      push(pmod1(0, 0, idx[0], idx[1], idx[2], 0));
      check($sformatf("tp_px%0d", p), if1.pmod_out);
    end
    if1.vid_blank = 1; step(); if1.vid_blank = 0;
    repeat (200) step();
    push(pmod1(0, 0, 1, 1, 0, 0)); check("tp_midline_before_rst", if1.pmod_out);
`else
    if1.vid_r = 1; if1.vid_g = 1; if1.vid_b = 0; if1.vid_blank = 0; if1.tp_en = 1;
    step();
    push(pmod1(0, 1, 1, 1, 0, 0)); check("tp_en_ignored", if1.pmod_out);
`endif

    // Asynchronous reset mid-line clears outputs without a clock edge.
    #2 rst_n = 1'b0;
    #1;
    push(8'h00); check("rst_async_pmod", if1.pmod_out);
    push(8'h42); check("rst_async_cfg", if1.cfg_active);
    push(0);     check("rst_async_level", if1.btn_level);
    step();
    rst_n = 1'b1;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
